secure_mem_arbiter: RTL and testbench
=====================================

Name: secure_mem_arbiter

Overview:
- Single-port arbiter and access controller in front of the 256-bit secure key/ID store.
- Shares the store between NUM_REQ on-chip requesters (e.g. boot FSM, crypto engine, lifecycle controller) using round-robin arbitration.
- Checks every access against per-requester read/write permission masks and per-slot sticky write locks.
- Sequences the store's rd_en/wr_en protocol and returns data or an error code to the requester.

Parameters:
- NUM_REQ, 3, number of requesters; must be 2..8.
- WIDTH, 256, data width; matches the secure memory word.
- LENGTH, 8, number of memory slots. ADDR_W = $clog2(LENGTH).
- RD_PERM, {NUM_REQ*LENGTH{1'b1}}, bit [r*LENGTH+s]=1 lets requester r read slot s.
- WR_PERM, {NUM_REQ*LENGTH{1'b0}}, bit [r*LENGTH+s]=1 lets requester r write slot s.
- LOCK_MASK, 8'h0F, slots that lock permanently after their first successful write.
- TIMEOUT, 4, number of cycles to wait for mem_rdData_valid before reporting an error.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester request; held high until gnt.
- req_we  in  NUM_REQ  1=write, 0=read.
- req_addr  in  NUM_REQ*ADDR_W  packed slot address per requester.
- req_wdata  in  NUM_REQ*WIDTH  packed write data per requester.
- gnt  out  NUM_REQ  one-hot single-cycle grant; request fields are sampled in this cycle.
- rsp_valid  out  NUM_REQ  one-hot single-cycle completion.
- rsp_data  out  WIDTH  read data; valid with rsp_valid; 0 for writes and errors.
- rsp_err  out  2  0=OK, 1=DENIED, 2=LOCKED, 3=TIMEOUT.
- lock_status  out  LENGTH  current sticky lock bits.
- mem_rd_en  out  1  to secure memory rd_en.
- mem_wr_en  out  1  to secure memory wr_en.
- mem_addr  out  ADDR_W  to secure memory addr.
- mem_wrData  out  WIDTH  to secure memory wrData.
- mem_rdData  in  WIDTH  from secure memory rdData.
- mem_rdData_valid  in  1  from secure memory rdData_valid.

Behaviour:
- Reset values: all outputs 0, FSM=IDLE, rr_ptr=0, lock bits=0, timeout counter=0.
- Reset asserted mid-transaction aborts it with no rsp_valid. Lock bits clear only on reset.
- FSM states: IDLE, ISSUE, WAIT_RD, RESP.
- IDLE:
  - If any req is high, the winner is the first set bit at or after rr_ptr (wrapping modulo NUM_REQ).
  - Pulse gnt[winner]; latch winner, we, addr and wdata; go to ISSUE.
  - With no req, stay in IDLE.
- ISSUE (permission check on the latched fields):
  - Read with RD_PERM bit clear, or write with WR_PERM bit clear: err=DENIED, go to RESP; no mem strobe.
  - Write to a slot whose lock bit is set: err=LOCKED, go to RESP; no mem strobe.
  - Permitted write: mem_wr_en=1 for exactly one cycle with mem_addr and mem_wrData. Set lock[addr] if LOCK_MASK[addr]. err=OK, go to RESP.
  - Permitted read: mem_rd_en=1 for exactly one cycle; go to WAIT_RD.
  - mem_rd_en and mem_wr_en are never high together.
- WAIT_RD:
  - mem_rd_en=0. Capture mem_rdData in the cycle mem_rdData_valid=1, because the memory zeroes rdData on the following cycle. err=OK, go to RESP.
  - If no valid arrives within TIMEOUT cycles: err=TIMEOUT, captured data=0, go to RESP.
- RESP:
  - rsp_valid[winner]=1 for one cycle with rsp_data/rsp_err; all are 0 in every other state.
  - rr_ptr = (winner+1) mod NUM_REQ; return to IDLE.
- Throughput and latency:
  - Write/denied: gnt to rsp_valid = 2 cycles.
  - Read: 3 cycles (gnt, ISSUE, WAIT_RD, RESP).
  - At most one transaction is in flight; no new gnt until the cycle after RESP.
- Out-of-range req_addr (>= LENGTH, non-power-of-two LENGTH only) returns DENIED.
- mem_addr and mem_wrData hold their last values when idle; only the strobes matter.

Decomposition:
- Package secure_mem_pkg holds:
  - typedef enum logic [1:0] sm_err_e {SM_OK, SM_DENIED, SM_LOCKED, SM_TIMEOUT};
  - FSM state enum;
  - default permission/lock mask constants for the key slots (2,3) and owner-ID slots (4..7).
- One sub-module, rr_arbiter: NUM_REQ-wide round-robin picker.
  - Inputs: req, ptr.
  - Outputs: one-hot grant and index.
  - Purely combinational; pointer state stays in the parent.

Test Plan:
- Read slot 3 by req0 (RD_PERM set), memory returns 256'h3F7A..596D one cycle after mem_rd_en -> rsp_valid[0] 3 cycles after gnt[0], rsp_data=256'h3F7A..596D, rsp_err=0.
- req0, req1 and req2 all asserted continuously with rr_ptr=0 -> gnt order 0,1,2,0; no requester is granted twice before the others.
- req1 writes slot 2 (WR_PERM set, LOCK_MASK[2]=1) twice -> first write: mem_wr_en one cycle, rsp_err=0, lock_status=8'h04; second write: no mem_wr_en, rsp_err=2.
- req2 reads slot 3 with RD_PERM bit clear -> no mem_rd_en, rsp_err=1, rsp_data=0, rsp_valid[2] 2 cycles after gnt.
- Memory model withholds mem_rdData_valid -> rsp_err=3 after TIMEOUT=4 WAIT_RD cycles, rsp_data=0; the next request is served normally.
- rst asserted during WAIT_RD -> all outputs 0 immediately, lock_status=0, no rsp_valid; after release the first grant goes to requester 0.

Source files
------------

// File: rtl/secure_mem_pkg.sv
// Shared types and default masks for the secure key/ID store arbiter.
package secure_mem_pkg;

  typedef enum logic [1:0] {SM_OK, SM_DENIED, SM_LOCKED, SM_TIMEOUT} sm_err_e;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT_RD, ST_RESP} sm_state_e;

  // Slot map of the 8-entry store: 2,3 hold keys, 4..7 hold owner IDs.
  localparam logic [7:0] KEY_SLOTS     = 8'h0C;
  localparam logic [7:0] OWNER_SLOTS   = 8'hF0;
  localparam logic [7:0] DEF_LOCK_MASK = 8'h0F;

endpackage

// File: rtl/secure_mem_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);

  localparam int SW = IDX_W + 1;

  logic [2*NUM_REQ-1:0] rot;
  logic [SW-1:0]        sum;
  logic                 found;

  // Rotating the doubled vector puts requester ptr at bit 0.
  assign rot = {req, req} >> ptr;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    sum   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, ptr} + SW'(k);
        if (sum >= SW'(NUM_REQ)) sum = sum - SW'(NUM_REQ);
        idx      = sum[IDX_W-1:0];
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/secure_mem_arbiter.sv
// Round-robin arbiter and access controller in front of the secure key/ID store.
module secure_mem_arbiter
  import secure_mem_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int WIDTH   = 256,
  parameter int LENGTH  = 8,
  parameter logic [NUM_REQ*LENGTH-1:0] RD_PERM = {NUM_REQ*LENGTH{1'b1}},
  parameter logic [NUM_REQ*LENGTH-1:0] WR_PERM = {NUM_REQ*LENGTH{1'b0}},
  parameter logic [LENGTH-1:0] LOCK_MASK = LENGTH'(DEF_LOCK_MASK),
  parameter int TIMEOUT = 4,
  localparam int ADDR_W = $clog2(LENGTH),
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [WIDTH-1:0]          rsp_data,
  output logic [1:0]                rsp_err,
  output logic [LENGTH-1:0]         lock_status,
  output logic                      mem_rd_en,
  output logic                      mem_wr_en,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [WIDTH-1:0]          mem_wrData,
  input  logic [WIDTH-1:0]          mem_rdData,
  input  logic                      mem_rdData_valid
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  sm_state_e            state, state_nxt;
  sm_err_e              err_q;
  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IDX_W-1:0]     arb_idx, rr_ptr, win_idx;
  logic                 win_we, sel_we;
  logic [ADDR_W-1:0]    win_addr, sel_addr;
  logic [WIDTH-1:0]     win_wdata, sel_wdata, rsp_data_q;
  logic [LENGTH-1:0]    lock, rd_row, wr_row;
  logic [TMO_W-1:0]     tmo_cnt;
  logic                 addr_ok, rd_ok, wr_ok, locked, tmo_hit;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req (req),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // Field mux for the arbitration winner and permission rows for the latched one.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    rd_row    = '0;
    wr_row    = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (arb_idx == IDX_W'(r)) begin
        sel_we    = req_we[r];
        sel_addr  = req_addr[r*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[r*WIDTH +: WIDTH];
      end
      if (win_idx == IDX_W'(r)) begin
        rd_row = RD_PERM[r*LENGTH +: LENGTH];
        wr_row = WR_PERM[r*LENGTH +: LENGTH];
      end
    end
  end

  assign addr_ok = int'(win_addr) < LENGTH;
  assign rd_ok   = addr_ok && rd_row[win_addr];
  assign wr_ok   = addr_ok && wr_row[win_addr];
  assign locked  = addr_ok && lock[win_addr];
  assign tmo_hit = tmo_cnt == TMO_W'(TIMEOUT - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    case (state)
      ST_IDLE:    if (|req) state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        if (!win_we && rd_ok) begin
          mem_rd_en = 1'b1;
          state_nxt = ST_WAIT_RD;
        end else begin
          mem_wr_en = win_we && wr_ok && !locked;
          state_nxt = ST_RESP;
        end
      end
      ST_WAIT_RD: if (mem_rdData_valid || tmo_hit) state_nxt = ST_RESP;
      ST_RESP:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= '0;
      win_idx    <= '0;
      win_we     <= 1'b0;
      win_addr   <= '0;
      win_wdata  <= '0;
      rsp_data_q <= '0;
      err_q      <= SM_OK;
      lock       <= '0;
      tmo_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: if (|req) begin
          win_idx   <= arb_idx;
          win_we    <= sel_we;
          win_addr  <= sel_addr;
          win_wdata <= sel_wdata;
        end
        ST_ISSUE: begin
          rsp_data_q <= '0;
          tmo_cnt    <= '0;
          if (win_we ? !wr_ok : !rd_ok) err_q <= SM_DENIED;
          else if (win_we && locked)    err_q <= SM_LOCKED;
          else                          err_q <= SM_OK;
          if (mem_wr_en && LOCK_MASK[win_addr]) lock[win_addr] <= 1'b1;
        end
        ST_WAIT_RD: begin
          // rdData is only valid in the strobe cycle, so capture it there.
          if (mem_rdData_valid) begin
            rsp_data_q <= mem_rdData;
            err_q      <= SM_OK;
          end else if (tmo_hit) begin
            rsp_data_q <= '0;
            err_q      <= SM_TIMEOUT;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_RESP: rr_ptr <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        default: ;
      endcase
    end
  end

  // Grant is gated by reset so a held request cannot be granted while in reset.
  assign gnt         = (state == ST_IDLE && !rst) ? arb_gnt : '0;
  assign rsp_valid   = (state == ST_RESP) ? (NUM_REQ'(1) << win_idx) : '0;
  assign rsp_data    = (state == ST_RESP) ? rsp_data_q : '0;
  assign rsp_err     = (state == ST_RESP) ? err_q : SM_OK;
  assign lock_status = lock;
  assign mem_addr    = win_addr;
  assign mem_wrData  = win_wdata;

endmodule

// File: tb/tb_secure_mem_arbiter.sv
// Directed scoreboard bench for secure_mem_arbiter with a delayed-valid memory model.
module tb_secure_mem_arbiter;

  localparam int NR = 3;
  localparam int W  = 256;
  localparam int L  = 8;
  localparam logic [255:0] K3 =
    256'h3F7A_1C2B_8D4E_9F60_A1B2_C3D4_E5F6_0718_293A_4B5C_6D7E_8F90_0112_2334_4556_596D;

  typedef struct {
    int           r;
    logic [1:0]   err;
    logic [255:0] data;
    int           lat;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req, req_we, gnt, rsp_valid;
  logic [NR*3-1:0] req_addr;
  logic [NR*W-1:0] req_wdata;
  logic [W-1:0]    rsp_data, mem_wrData, mem_rdData;
  logic [1:0]      rsp_err;
  logic [L-1:0]    lock_status;
  logic            mem_rd_en, mem_wr_en, mem_rdData_valid;
  logic [2:0]      mem_addr;

  secure_mem_arbiter #(
    .NUM_REQ(NR), .WIDTH(W), .LENGTH(L),
    .RD_PERM(24'hF7FFFF), .WR_PERM(24'h000420),
    .LOCK_MASK(8'h0F), .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .lock_status(lock_status), .mem_rd_en(mem_rd_en),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wrData(mem_wrData),
    .mem_rdData(mem_rdData), .mem_rdData_valid(mem_rdData_valid)
  );

  always #5 clk = ~clk;

  int   n_assert = 0, n_fail = 0;
  int   cyc = 0, gnt_cyc = 0, mon_idx = 0, dropped = 0;
  int   issued[NR] = '{default: 0};
  int   gcnt[NR]   = '{default: 0};
  int   rd_delay = 1, rd_count = 0, wr_count = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [W-1:0] mem[L];

  task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] pat(int s);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(s);
    return (s == 3) ? K3 : {8{w}};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: rdData_valid for one cycle rd_delay cycles after rd_en (0 = never).
  initial begin
    int cd, rd_addr;
    cd = 0; rd_addr = 0;
    for (int s = 0; s < L; s++) mem[s] = pat(s);
    mem_rdData = '0;
    mem_rdData_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mem_rdData_valid = 1'b0; mem_rdData = '0; cd = 0;
      end else begin
        if (mem_rdData_valid) begin mem_rdData_valid = 1'b0; mem_rdData = '0; end
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin mem_rdData_valid = 1'b1; mem_rdData = mem[rd_addr]; end
        end
        if (mem_rd_en) begin rd_count++; rd_addr = int'(mem_addr); cd = rd_delay; end
        if (mem_wr_en) begin wr_count++; mem[mem_addr] = mem_wrData; end
      end
    end
  end

  // Monitor: grant order and responses against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (gnt != '0) begin
        gnt_cyc = cyc;
        if (mon_idx + dropped < exp_q.size())
          chk("gnt_order", gnt, 3'b001 << exp_q[mon_idx + dropped].r);
        else chk("gnt_unexpected", gnt, '0);
        for (int r = 0; r < NR; r++) if (gnt[r]) gcnt[r]++;
      end
      if (rsp_valid != '0) begin
        if (mon_idx + dropped < exp_q.size()) begin
          mon_e = exp_q[mon_idx + dropped];
          mon_idx++;
          chk("rsp_valid", rsp_valid, 3'b001 << mon_e.r);
          chk("rsp_err", rsp_err, mon_e.err);
          chk("rsp_data", rsp_data, mon_e.data);
          chk("rsp_latency", cyc - gnt_cyc, mon_e.lat);
        end else chk("rsp_unexpected", rsp_valid, '0);
      end
    end
    if (mem_rd_en || mem_wr_en) chk("strobe_excl", mem_rd_en & mem_wr_en, 1'b0);
  end

  task automatic issue(int r, bit we, logic [2:0] a, logic [255:0] d,
                       logic [1:0] err, logic [255:0] ed, int lat);
    req_we[r] = we;
    req_addr[r*3 +: 3] = a;
    req_wdata[r*W +: W] = d;
    issued[r]++;
    req[r] = 1'b1;
    exp_q.push_back('{r: r, err: err, data: ed, lat: lat});
  endtask

  task automatic wait_done(int budget);
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(posedge clk); #1;
      n++;
      done = (mon_idx + dropped == exp_q.size());
      for (int r = 0; r < NR; r++) begin
        req[r] = issued[r] > gcnt[r];
        if (req[r]) done = 1'b0;
      end
    end
    chk("txn_complete", done, 1'b1);
  endtask

  task automatic chk_quiet(string tag);
    chk({tag, "_gnt"}, gnt, '0);
    chk({tag, "_rsp_valid"}, rsp_valid, '0);
    chk({tag, "_rsp_data"}, rsp_data, '0);
    chk({tag, "_rsp_err"}, rsp_err, '0);
    chk({tag, "_lock"}, lock_status, '0);
    chk({tag, "_rd_en"}, mem_rd_en, 1'b0);
    chk({tag, "_wr_en"}, mem_wr_en, 1'b0);
    chk({tag, "_addr"}, mem_addr, '0);
    chk({tag, "_wrdata"}, mem_wrData, '0);
  endtask

  initial begin
    int n;
    rst = 1'b1; req = '1; req_we = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_quiet("reset");
    req = '0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Fairness from rr_ptr=0: 0,1,2 then 0 again.
    issue(0, 0, 3'd0, '0, 2'd0, pat(0), 3);
    issue(1, 0, 3'd1, '0, 2'd0, pat(1), 3);
    issue(2, 0, 3'd4, '0, 2'd0, pat(4), 3);
    issue(0, 0, 3'd0, '0, 2'd0, pat(0), 3);
    wait_done(100);
    chk("rr_rd_count", rd_count, 4);

    issue(0, 0, 3'd3, '0, 2'd0, K3, 3);
    wait_done(30);

    issue(1, 1, 3'd2, {8{32'h1111_2222}}, 2'd0, '0, 2);
    wait_done(30);
    chk("wr1_count", wr_count, 1);
    chk("wr1_mem", mem[2], {8{32'h1111_2222}});
    chk("wr1_lock", lock_status, 8'h04);

    issue(1, 1, 3'd2, {8{32'h3333_4444}}, 2'd2, '0, 2);
    wait_done(30);
    chk("wr2_count", wr_count, 1);
    chk("wr2_mem", mem[2], {8{32'h1111_2222}});

    issue(2, 0, 3'd3, '0, 2'd1, '0, 2);
    wait_done(30);
    chk("deny_rd_count", rd_count, 5);

    issue(0, 1, 3'd0, {8{32'h5555_6666}}, 2'd1, '0, 2);
    wait_done(30);
    chk("deny_wr_count", wr_count, 1);

    // Slot 5 is writable but outside the lock mask: rewrites stay OK.
    issue(0, 1, 3'd5, {8{32'h7777_8888}}, 2'd0, '0, 2);
    issue(0, 1, 3'd5, {8{32'h9999_AAAA}}, 2'd0, '0, 2);
    wait_done(40);
    chk("slot5_count", wr_count, 3);
    chk("slot5_mem", mem[5], {8{32'h9999_AAAA}});
    chk("slot5_lock", lock_status, 8'h04);

    rd_delay = 4;
    issue(1, 0, 3'd1, '0, 2'd0, pat(1), 6);
    wait_done(40);

    rd_delay = 0;
    issue(2, 0, 3'd4, '0, 2'd3, '0, 6);
    wait_done(40);

    rd_delay = 1;
    issue(1, 0, 3'd0, '0, 2'd0, pat(0), 3);
    wait_done(30);
    issue(0, 0, 3'd6, '0, 2'd0, pat(6), 3);
    wait_done(30);
    chk("pre_abort_rd_count", rd_count, 9);

    // Abort a read stuck in WAIT_RD with reset.
    rd_delay = 0;
    issue(0, 0, 3'd7, '0, 2'd0, pat(7), 3);
    n = 0;
    while (gcnt[0] != issued[0] && n < 20) begin @(posedge clk); #1; n++; end
    req[0] = 1'b0;
    chk("abort_granted", gcnt[0], issued[0]);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk_quiet("abort");
    dropped++;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_rd_count", rd_count, 10);

    rd_delay = 1;
    issue(0, 0, 3'd1, '0, 2'd0, pat(1), 3);
    issue(1, 0, 3'd0, '0, 2'd0, pat(0), 3);
    wait_done(60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
